// File: rtl/hmem_port_arbiter_pkg.sv
// Shared types for the hmem port arbiter: FSM state encoding, memory op encoding,
// requester indices and the starvation-counter width helper.
package hmem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN_L2  = 2'd1,
        OWN_DBG = 2'd2
    } hmem_arb_state_e;

    typedef enum logic {
        MEM_LOAD  = 1'b0,
        MEM_STORE = 1'b1
    } mem_op_e;

    localparam int unsigned REQ_L2  = 0;
    localparam int unsigned REQ_DBG = 1;
    localparam int unsigned NUM_REQ = 2;

    // Bits needed to hold 0..limit inclusive.
    function automatic int unsigned starve_cnt_width(input int unsigned limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/hmem_port_arbiter_if.sv
// Bundle of the two requester ports and the shared main-memory port.
// The slave modport is the arbiter's view; master is the requesters plus memory model.
interface hmem_port_arbiter_if #(
    parameter int XLEN = 32
);
    logic            l2_valid;
    logic            l2_op;
    logic [XLEN-1:0] l2_addr;
    logic [XLEN-1:0] l2_wdata;
    logic            l2_fulfilled;
    logic [XLEN-1:0] l2_rdata;

    logic            dbg_valid;
    logic            dbg_op;
    logic [XLEN-1:0] dbg_addr;
    logic [XLEN-1:0] dbg_wdata;
    logic            dbg_fulfilled;
    logic [XLEN-1:0] dbg_rdata;

    logic            hmem_valid;
    logic            hmem_op;
    logic [XLEN-1:0] hmem_addr;
    logic [XLEN-1:0] hmem_wdata;
    logic            hmem_fulfilled;
    logic [XLEN-1:0] hmem_rdata;

    modport slave (
        input  l2_valid, l2_op, l2_addr, l2_wdata,
        output l2_fulfilled, l2_rdata,
        input  dbg_valid, dbg_op, dbg_addr, dbg_wdata,
        output dbg_fulfilled, dbg_rdata,
        output hmem_valid, hmem_op, hmem_addr, hmem_wdata,
        input  hmem_fulfilled, hmem_rdata
    );

    modport master (
        output l2_valid, l2_op, l2_addr, l2_wdata,
        input  l2_fulfilled, l2_rdata,
        output dbg_valid, dbg_op, dbg_addr, dbg_wdata,
        input  dbg_fulfilled, dbg_rdata,
        input  hmem_valid, hmem_op, hmem_addr, hmem_wdata,
        output hmem_fulfilled, hmem_rdata
    );

endinterface

// File: rtl/hmem_port_arbiter_starve_ctr.sv
// Saturating up-counter tracking how long the debug requester has been passed over.
// Clear has priority over increment; sat is high once the count equals LIMIT.
module hmem_arb_starve_ctr
    import hmem_port_arbiter_pkg::*;
#(
    parameter int unsigned LIMIT = 16,
    parameter int unsigned CW    = starve_cnt_width(LIMIT)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign sat = (cnt_q == CW'(LIMIT));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !sat) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/hmem_port_arbiter.sv
// Transaction-locked arbiter sharing the hmem port between L2 (fixed priority) and a
// debug loader, with a starvation override that forces a debug grant after a bounded wait.
module hmem_port_arbiter
    import hmem_port_arbiter_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 16,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    hmem_port_arbiter_if.slave bus,
    output logic [CNT_W-1:0] l2_grants,
    output logic [CNT_W-1:0] dbg_grants
);

    hmem_arb_state_e    state_q;
    hmem_arb_state_e    state_d;
    logic               starve_sat;
    logic               grant_l2;
    logic               grant_dbg;
    logic [NUM_REQ-1:0] grant_vec;
    logic               mux_op;
    logic [XLEN-1:0]    mux_addr;
    logic [XLEN-1:0]    mux_wdata;

    // Only IDLE grants; with both requesting, debug wins only once it has starved.
    always_comb begin
        grant_l2  = 1'b0;
        grant_dbg = 1'b0;
        if (state_q == IDLE) begin
            if (bus.l2_valid && bus.dbg_valid) begin
                grant_dbg = starve_sat;
                grant_l2  = !starve_sat;
            end else begin
                grant_l2  = bus.l2_valid;
                grant_dbg = bus.dbg_valid;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_dbg) begin
                    state_d = OWN_DBG;
                end else if (grant_l2) begin
                    state_d = OWN_L2;
                end
            end
            OWN_L2, OWN_DBG: begin
                if (bus.hmem_fulfilled) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    hmem_arb_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (bus.dbg_valid && (state_q != OWN_DBG)),
        .clr     (grant_dbg),
        .sat     (starve_sat)
    );

    assign grant_vec[REQ_L2]  = grant_l2;
    assign grant_vec[REQ_DBG] = grant_dbg;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant_cnt
        logic [CNT_W-1:0] cnt_q;
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt_q <= '0;
            end else if (grant_vec[gi]) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign l2_grants  = g_grant_cnt[REQ_L2].cnt_q;
    assign dbg_grants = g_grant_cnt[REQ_DBG].cnt_q;

    // The mux follows the owner's live request lines; zero whenever nobody owns the port.
    always_comb begin
        mux_op    = 1'b0;
        mux_addr  = '0;
        mux_wdata = '0;
        case (state_q)
            OWN_L2: begin
                mux_op    = bus.l2_op;
                mux_addr  = bus.l2_addr;
                mux_wdata = bus.l2_wdata;
            end
            OWN_DBG: begin
                mux_op    = bus.dbg_op;
                mux_addr  = bus.dbg_addr;
                mux_wdata = bus.dbg_wdata;
            end
            default: begin
                mux_op    = 1'b0;
                mux_addr  = '0;
                mux_wdata = '0;
            end
        endcase
    end

    assign bus.hmem_valid = (state_q != IDLE);
    assign bus.hmem_op    = mux_op;
    assign bus.hmem_addr  = mux_addr;
    assign bus.hmem_wdata = mux_wdata;

    // A completion arriving in IDLE reaches neither requester.
    assign bus.l2_fulfilled  = bus.hmem_fulfilled && (state_q == OWN_L2);
    assign bus.dbg_fulfilled = bus.hmem_fulfilled && (state_q == OWN_DBG);
    assign bus.l2_rdata      = (state_q == OWN_L2)  ? bus.hmem_rdata : '0;
    assign bus.dbg_rdata     = (state_q == OWN_DBG) ? bus.hmem_rdata : '0;

    // The owner must hold its request until completion; ownership is kept regardless.
    a_l2_holds_valid: assert property (
        @(posedge clk) disable iff (!reset_n) (state_q == OWN_L2) |-> bus.l2_valid
    );
    a_dbg_holds_valid: assert property (
        @(posedge clk) disable iff (!reset_n) (state_q == OWN_DBG) |-> bus.dbg_valid
    );

endmodule
